jtvigil_bank_arb: RTL and testbench
===================================

Name: jtvigil_bank_arb

Overview:
- Shares one read-only SDRAM bank between three byte-wide ROM requesters: slot 0 main CPU, slot 1 sound CPU, slot 2 PCM.
- Each slot has a one-word (16-bit) cache and requests the bank only on a miss.
- Misses are served in round-robin order through the bank's rd/ack/dst/dok/rdy handshake.
- Sits between the CPU/sound ROM ports and the bank 0 channel of the SDRAM controller.

Parameters:
- S0_AW, 18, slot 0 byte-address width
- S1_AW, 16, slot 1 byte-address width
- S2_AW, 16, slot 2 byte-address width
- S1_OFFSET, 22'h0, slot 1 word offset inside the bank
- S2_OFFSET, 22'h0, slot 2 word offset inside the bank (slot 0 offset fixed at 0)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- downloading  in  1  ROM download in progress
- s0_cs  in  1  slot 0 request
- s0_addr  in  S0_AW  slot 0 byte address
- s0_data  out  8  slot 0 read data
- s0_ok  out  1  slot 0 data valid
- s1_cs, s1_addr, s1_data, s1_ok  same as slot 0, width S1_AW
- s2_cs, s2_addr, s2_data, s2_ok  same as slot 0, width S2_AW
- ba_addr  out  22  bank word address
- ba_rd  out  1  bank read request
- ba_ack  in  1  request accepted
- ba_dst  in  1  data start
- ba_dok  in  1  data word valid
- ba_rdy  in  1  transfer complete
- data_read  in  16  SDRAM data bus

Behaviour:
- Reset: ba_rd=0, ba_addr=0, all cache words=0, valid bits=0, round-robin pointer=slot 0, FSM=IDLE. Resulting outputs: every sN_ok=0, every sN_data=0.
- Hit (combinational):
  - hitN = sN_cs & validN & (tagN == sN_addr[AW-1:1]).
  - sN_ok = hitN.
  - sN_data = sN_addr[0] ? wordN[15:8] : wordN[7:0], at all times.
  - A hit costs zero bank cycles.
- Miss: missN = sN_cs & ~hitN & ~downloading.
- FSM IDLE:
  - If any miss, grant the first missing slot starting at the round-robin pointer and wrapping 2→0.
  - Latch the granted slot index and word address.
  - ba_addr <= offset + sN_addr[AW-1:1], zero-extended to 22 bits.
  - ba_rd <= 1; go to REQ.
  - The pointer becomes grant+1 (mod 3).
- FSM REQ: hold ba_rd and ba_addr stable until ba_ack. On ack: ba_rd <= 0, go to WAIT.
- FSM WAIT:
  - On the cycle ba_dok & ba_rdy are both high, capture data_read into the granted slot's word.
  - Set the slot's tag to the latched address and set its valid bit.
  - Return to IDLE.
  - ba_dst is unused for control.
- Minimum miss latency: cs/addr change → ba_rd at +1 clk; ok one clk after the rdy cycle.
- Back-to-back: a new grant can be issued on the clk after the return to IDLE; there is no dead cycle beyond that.
- Fairness: with all three slots missing continuously, grants go 0,1,2,0,...
- Boundary conditions:
  - cs drops or addr changes during REQ/WAIT: the transaction completes and the cache fills with the latched tag. A changed address then misses and is served as a new request.
  - downloading high: all valid bits cleared every cycle and no new grant. An in-flight transaction completes its handshake, but its data is discarded (valid stays 0).
  - Hit and miss in the same cycle on different slots: the hit is served combinationally, independently of the arbiter.
  - Reset asserted mid-transaction: immediate return to reset state, ba_rd=0.

Test Plan:
- Reset, then s0_cs=1, s0_addr=18'h00101:
  - ba_rd rises after 1 clk with ba_addr=22'h00080.
  - Ack, then rdy with data_read=16'hA55A → s0_ok=1, s0_data=8'hA5.
  - Change to 18'h00100 → s0_data=8'h5A with no new ba_rd.
- All three slots miss simultaneously, S1_OFFSET=22'h20000, S2_OFFSET=22'h28000, addresses 0x10/0x20/0x30:
  - Grants in order 0,1,2 with ba_addr 22'h8, 22'h20010, 22'h28018.
  - Each ok rises only after its own rdy.
- s1 changes address from 16'h0002 to 16'h0004 between ack and rdy:
  - Fill tags word 1; s1_ok stays 0.
  - A second request for ba_addr=S1_OFFSET+2 follows.
- Slot 0 hit on a cached word while slot 2 has an outstanding miss: s0_ok=1 the same cycle; the slot 2 handshake is unaffected.
- downloading rises during WAIT:
  - Rdy completes and ba_rd stays 0.
  - After downloading falls, the same address misses again and refetches.
- ba_ack withheld for 20 clks: ba_rd and ba_addr are held constant throughout; no ok asserts.

Source files
------------

// File: rtl/jtvigil_bank_arb_if.sv
// jtvigil_bank_arb_if: bank 0 SDRAM read channel (addr/rd from arbiter; ack/dst/dok/rdy/data_read from controller)
interface jtvigil_bank_arb_if;
  logic [21:0] addr;
  logic        rd, ack, dst, dok, rdy;
  logic [15:0] data_read;
  modport master(output addr, rd, input ack, dst, dok, rdy, data_read);
  modport slave(input addr, rd, output ack, dst, dok, rdy, data_read);
endinterface

// File: rtl/jtvigil_bank_arb.sv
// jtvigil_bank_arb: three one-word ROM caches (sN_cs/sN_addr in, sN_data/sN_ok out) refilled round-robin over one SDRAM bank (ba)
module jtvigil_bank_arb #(
  parameter int          S0_AW     = 18,
  parameter int          S1_AW     = 16,
  parameter int          S2_AW     = 16,
  parameter logic [21:0] S1_OFFSET = 22'h0,
  parameter logic [21:0] S2_OFFSET = 22'h0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             downloading,
  input  logic             s0_cs,
  input  logic [S0_AW-1:0] s0_addr,
  output logic [7:0]       s0_data,
  output logic             s0_ok,
  input  logic             s1_cs,
  input  logic [S1_AW-1:0] s1_addr,
  output logic [7:0]       s1_data,
  output logic             s1_ok,
  input  logic             s2_cs,
  input  logic [S2_AW-1:0] s2_addr,
  output logic [7:0]       s2_data,
  output logic             s2_ok,
  jtvigil_bank_arb_if.master ba
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t             st, st_nx;
  logic [2:0][21:0]   wa, tag, off;
  logic [2:0][15:0]   word;
  logic [2:0][7:0]    dout;
  logic [2:0]         cs_v, lsb, valid, hit, miss, rot;
  logic [21:0]        lat;
  logic [1:0]         ptr, gnt, sel, ofs;
  logic [2:0]         sum;
  logic               fill, unused_dst;
  assign unused_dst = ba.dst;
  assign wa   = {22'(s2_addr[S2_AW-1:1]), 22'(s1_addr[S1_AW-1:1]), 22'(s0_addr[S0_AW-1:1])};
  assign off  = {S2_OFFSET, S1_OFFSET, 22'd0};
  assign cs_v = {s2_cs, s1_cs, s0_cs};
  assign lsb  = {s2_addr[0], s1_addr[0], s0_addr[0]};
  for (genvar g = 0; g < 3; g++) begin : g_slot
    assign hit[g]  = cs_v[g] & valid[g] & (tag[g] == wa[g]);
    assign miss[g] = cs_v[g] & ~hit[g] & ~downloading;
    assign dout[g] = lsb[g] ? word[g][15:8] : word[g][7:0];
  end
  assign {s2_ok, s1_ok, s0_ok}       = hit;
  assign {s2_data, s1_data, s0_data} = dout;
  // rotate misses so bit 0 is the slot under the pointer, then take the first set bit
  assign rot  = ptr == 2'd1 ? {miss[0], miss[2:1]} : ptr == 2'd2 ? {miss[1:0], miss[2]} : miss;
  assign ofs  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
  assign sum  = 3'(ptr) + 3'(ofs);
  assign sel  = 2'(sum >= 3'd3 ? sum - 3'd3 : sum);
  assign fill = st == WAIT & ba.dok & ba.rdy;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else     st <= st_nx;
  always_comb
    st_nx = st == IDLE ? (|miss ? REQ : IDLE) : st == REQ ? (ba.ack ? WAIT : REQ) : (fill ? IDLE : WAIT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ba.rd   <= 1'b0;
      ba.addr <= '0;
      word    <= '0;
      tag     <= '0;
      valid   <= '0;
      ptr     <= '0;
      gnt     <= '0;
      lat     <= '0;
    end else begin
      if (st == IDLE && |miss) begin
        gnt     <= sel;
        lat     <= wa[sel];
        ba.addr <= off[sel] + wa[sel];
        ba.rd   <= 1'b1;
        ptr     <= sel == 2'd2 ? 2'd0 : 2'(sel + 2'd1);
      end
      if (st == REQ && ba.ack) ba.rd <= 1'b0;
      if (fill) begin
        word[gnt] <= ba.data_read;
        tag[gnt]  <= lat;
      end
      // a fill that lands while downloading is dropped by never setting its valid bit
      valid <= downloading ? 3'd0 : valid | (fill ? 3'b001 << gnt : 3'd0);
    end
endmodule

// File: tb/tb_jtvigil_bank_arb.sv
// tb_jtvigil_bank_arb: directed plus randomized check of jtvigil_bank_arb against a transaction-level cache model
module tb_jtvigil_bank_arb;
  localparam logic [21:0] OFF1 = 22'h20000;
  localparam logic [21:0] OFF2 = 22'h28000;
  logic        clk = 0, rst = 1, downloading = 0;
  logic        s0_cs = 0, s1_cs = 0, s2_cs = 0;
  logic [17:0] s0_addr = 0;
  logic [15:0] s1_addr = 0, s2_addr = 0;
  logic [7:0]  s0_data, s1_data, s2_data;
  logic        s0_ok, s1_ok, s2_ok;
  int          vectors = 0, errors = 0;
  jtvigil_bank_arb_if ba();
  jtvigil_bank_arb #(.S1_OFFSET(OFF1), .S2_OFFSET(OFF2)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .s0_cs(s0_cs), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ok(s0_ok),
    .s1_cs(s1_cs), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ok(s1_ok),
    .s2_cs(s2_cs), .s2_addr(s2_addr), .s2_data(s2_data), .s2_ok(s2_ok),
    .ba(ba)
  );
  always #5 clk = ~clk;
  // model: per-slot cached word plus one outstanding bank transaction
  logic        mv [3];
  logic [21:0] mtag [3];
  logic [15:0] mword [3];
  bit          busy, acked;
  int          tslot, ptr;
  logic [21:0] tword, baddr;
  function automatic logic [21:0] wa(int n);
    return n == 0 ? 22'(s0_addr >> 1) : n == 1 ? 22'(s1_addr >> 1) : 22'(s2_addr >> 1);
  endfunction
  function automatic logic cs(int n);
    return n == 0 ? s0_cs : n == 1 ? s1_cs : s2_cs;
  endfunction
  function automatic logic eok(int n);
    return cs(n) && mv[n] && mtag[n] == wa(n);
  endfunction
  function automatic logic [7:0] edata(int n);
    logic odd;
    odd = n == 0 ? s0_addr[0] : n == 1 ? s1_addr[0] : s2_addr[0];
    return odd ? mword[n][15:8] : mword[n][7:0];
  endfunction
  function automatic logic dut_ok(int n);
    return n == 0 ? s0_ok : n == 1 ? s1_ok : s2_ok;
  endfunction
  function automatic logic [7:0] dut_data(int n);
    return n == 0 ? s0_data : n == 1 ? s1_data : s2_data;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset;
    for (int n = 0; n < 3; n++) begin
      mv[n] = 0; mtag[n] = 0; mword[n] = 0;
    end
    busy = 0; acked = 0; tslot = 0; ptr = 0; tword = 0; baddr = 0;
  endtask
  task automatic model_update;
    if (!busy) begin
      for (int i = 0; i < 3; i++) begin
        int k;
        k = (ptr + i) % 3;
        if (!busy && !downloading && cs(k) && !eok(k)) begin
          busy = 1; acked = 0; tslot = k; tword = wa(k);
          baddr = (k == 1 ? OFF1 : k == 2 ? OFF2 : 22'h0) + tword;
          ptr = (k + 1) % 3;
        end
      end
    end else if (!acked) acked = ba.ack;
    else if (ba.dok && ba.rdy) begin
      mword[tslot] = ba.data_read;
      mtag[tslot]  = tword;
      if (!downloading) mv[tslot] = 1;
      busy = 0;
    end
    if (downloading) for (int n = 0; n < 3; n++) mv[n] = 0;
  endtask
  task automatic compare;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("s%0d_ok", n), 32'(dut_ok(n)), 32'(eok(n)));
      if (eok(n)) chk($sformatf("s%0d_data", n), 32'(dut_data(n)), 32'(edata(n)));
    end
    chk("ba_rd", 32'(ba.rd), 32'(busy && !acked));
    chk("ba_addr", 32'(ba.addr), 32'(baddr));
  endtask
  task automatic step;
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst = 1; downloading = 0;
    s0_cs = 1; s1_cs = 1; s2_cs = 1;
    s0_addr = 18'h155; s1_addr = 16'h2AA; s2_addr = 16'h3;
    ba.ack = 0; ba.dok = 0; ba.rdy = 0; ba.dst = 0; ba.data_read = 16'hFFFF;
    model_reset();
    #1;
    chk("rst_rd", 32'(ba.rd), 0);
    chk("rst_addr", 32'(ba.addr), 0);
    chk("rst_ok", 32'({s2_ok, s1_ok, s0_ok}), 0);
    chk("rst_data", 32'({s2_data, s1_data, s0_data}), 0);
    @(negedge clk);
    rst = 0; s0_cs = 0; s1_cs = 0; s2_cs = 0;
  endtask
  task automatic txn(input string name, input logic [21:0] ea, input logic [15:0] d);
    chk({name, "_rd"}, 32'(ba.rd), 1);
    chk({name, "_addr"}, 32'(ba.addr), 32'(ea));
    ba.ack = 1;
    step();
    ba.ack = 0; ba.dok = 1; ba.rdy = 1; ba.data_read = d;
    step();
    ba.dok = 0; ba.rdy = 0;
  endtask
  initial begin
    do_reset();
    s0_cs = 1; s0_addr = 18'h00101;
    step();
    txn("t1", 22'h00080, 16'hA55A);
    chk("t1_ok", 32'(s0_ok), 1);
    chk("t1_hi", 32'(s0_data), 32'h A5);
    s0_addr = 18'h00100;
    step();
    chk("t1_lo", 32'(s0_data), 32'h5A);
    chk("t1_norq", 32'(ba.rd), 0);
    do_reset();
    s0_cs = 1; s1_cs = 1; s2_cs = 1;
    s0_addr = 18'h10; s1_addr = 16'h20; s2_addr = 16'h30;
    step();
    txn("t2a", 22'h00008, 16'h1111);
    chk("t2a_ok", 32'({s2_ok, s1_ok, s0_ok}), 32'b001);
    step();
    txn("t2b", 22'h20010, 16'h2222);
    chk("t2b_ok", 32'({s2_ok, s1_ok, s0_ok}), 32'b011);
    step();
    txn("t2c", 22'h28018, 16'h3333);
    chk("t2c_ok", 32'({s2_ok, s1_ok, s0_ok}), 32'b111);
    chk("t2c_data", 32'(s2_data), 32'h33);
    do_reset();
    s1_cs = 1; s1_addr = 16'h0002;
    step();
    chk("t3_rd", 32'(ba.rd), 1);
    chk("t3_addr", 32'(ba.addr), 32'(22'h20001));
    ba.ack = 1;
    step();
    ba.ack = 0; s1_addr = 16'h0004; ba.dok = 1; ba.rdy = 1; ba.data_read = 16'hBEEF;
    step();
    ba.dok = 0; ba.rdy = 0;
    chk("t3_ok", 32'(s1_ok), 0);
    step();
    txn("t3b", 22'h20002, 16'hCAFE);
    chk("t3b_ok", 32'(s1_ok), 1);
    chk("t3b_data", 32'(s1_data), 32'hFE);
    s1_cs = 0; s0_cs = 1; s0_addr = 18'h00200;
    step();
    txn("t4a", 22'h00100, 16'h1234);
    s0_cs = 0; s2_cs = 1; s2_addr = 16'h0006;
    step();
    s0_cs = 1; s0_addr = 18'h00201;
    #1;
    chk("t4_hit", 32'(s0_ok), 1);
    chk("t4_hdata", 32'(s0_data), 32'h12);
    txn("t4b", 22'h28003, 16'h5678);
    chk("t4b_ok", 32'({s2_ok, s0_ok}), 32'b11);
    s0_cs = 0; s2_cs = 0; s1_cs = 1; s1_addr = 16'h0010;
    step();
    chk("t5_addr", 32'(ba.addr), 32'(22'h20008));
    ba.ack = 1;
    step();
    ba.ack = 0; downloading = 1;
    step();
    ba.dok = 1; ba.rdy = 1; ba.data_read = 16'h9999;
    step();
    ba.dok = 0; ba.rdy = 0;
    chk("t5_ok", 32'(s1_ok), 0);
    chk("t5_rd", 32'(ba.rd), 0);
    step();
    step();
    chk("t5_rd2", 32'(ba.rd), 0);
    downloading = 0;
    step();
    txn("t5b", 22'h20008, 16'h4242);
    chk("t5b_ok", 32'(s1_ok), 1);
    s1_cs = 0; s2_cs = 1; s2_addr = 16'h0100;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_rd", 32'(ba.rd), 1);
      chk("t6_addr", 32'(ba.addr), 32'(22'h28080));
      chk("t6_ok", 32'(s2_ok), 0);
    end
    txn("t6", 22'h28080, 16'h7777);
    s2_cs = 0; s0_cs = 1; s0_addr = 18'h3FFFF;
    step();
    chk("t7_rd", 32'(ba.rd), 1);
    chk("t7_addr", 32'(ba.addr), 32'(22'h1FFFF));
    rst = 1;
    #1;
    chk("t7_rst_rd", 32'(ba.rd), 0);
    chk("t7_rst_addr", 32'(ba.addr), 0);
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) s0_cs = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) s1_cs = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) s2_cs = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) s0_addr = 18'($urandom_range(0, 7)) | ($urandom_range(0, 7) == 0 ? 18'h20000 : 18'h0);
      if ($urandom_range(0, 3) == 0) s1_addr = 16'($urandom_range(0, 7)) | ($urandom_range(0, 7) == 0 ? 16'h8000 : 16'h0);
      if ($urandom_range(0, 3) == 0) s2_addr = 16'($urandom_range(0, 7));
      downloading = downloading ? $urandom_range(0, 3) != 0 : $urandom_range(0, 59) == 0;
      ba.ack = (busy && !acked) ? $urandom_range(0, 2) == 0 : $urandom_range(0, 7) == 0;
      ba.dok = $urandom_range(0, 1) == 1;
      ba.rdy = (busy && acked) ? $urandom_range(0, 1) == 0 : $urandom_range(0, 7) == 0;
      ba.dst = $urandom_range(0, 1) == 1;
      ba.data_read = 16'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
